bus_arb: RTL and testbench

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_arb.sv | 179 +++++++++++++++++
 tb/tb_bus_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb.sv
// Two-master round-robin arbiter for a single shared bus.
// It latches the winning request and aborts the transaction after TIMEOUT cycles with no slave response.
module bus_arb #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_rw,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_rw,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_rw,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rdy
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_valid_q, bus_valid_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_rw_q, bus_rw_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic        m0_err_q, m0_err_d;
    logic        m1_err_q, m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    logic elig0, elig1, pick1, done, timed_out;

    // A requester whose ack is high this cycle is not re-granted.
    assign elig0 = m0_req & ~m0_ack_q;
    assign elig1 = m1_req & ~m1_ack_q;

    // Next-state, grant selection and completion handling.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_rw_d    = bus_rw_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_err_d    = m0_err_q;
        m1_err_d    = m1_err_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        pick1       = 1'b0;
        done        = 1'b0;
        timed_out   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    // On a tie, last_q = 1 (m1 served last) favours m0.
                    pick1       = elig1 & (~elig0 | ~last_q);
                    owner_d     = pick1;
                    bus_addr_d  = pick1 ? m1_addr : m0_addr;
                    bus_wdata_d = pick1 ? m1_wdata : m0_wdata;
                    bus_rw_d    = pick1 ? m1_rw : m0_rw;
                    cnt_d       = 8'd0;
                    bus_valid_d = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (bus_rdy) begin
                    done = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (done) begin
                    state_d     = IDLE;
                    bus_valid_d = 1'b0;
                    last_d      = owner_q;
                    if (owner_q) begin
                        m1_ack_d = 1'b1;
                        m1_err_d = timed_out;
                        if (timed_out) begin
                            m1_rdata_d = 32'h0;
                        end else if (!bus_rw_q) begin
                            m1_rdata_d = bus_rdata;
                        end
                    end else begin
                        m0_ack_d = 1'b1;
                        m0_err_d = timed_out;
                        if (timed_out) begin
                            m0_rdata_d = 32'h0;
                        end else if (!bus_rw_q) begin
                            m0_rdata_d = bus_rdata;
                        end
                    end
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 8'd0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_rw_q    <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            m0_rdata_q  <= 32'h0;
            m1_rdata_q  <= 32'h0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_rw_q    <= bus_rw_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_err_q    <= m0_err_d;
            m1_err_q    <= m1_err_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_err    = m0_err_q;
    assign m1_err    = m1_err_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_rw    = bus_rw_q;

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: a vector table, directed corner sequences,
// and a random run compared against a transaction-level model.
module tb_bus_arb;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_rw, m1_req, m1_rw;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_valid, bus_rw, bus_rdy;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_arb #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rw(bus_rw), .bus_rdata(bus_rdata), .bus_rdy(bus_rdy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input int m, input logic r, input logic [31:0] a,
                             input logic [31:0] wd, input logic rw);
        if (m == 0) begin
            m0_req = r; m0_addr = a; m0_wdata = wd; m0_rw = rw;
        end else begin
            m1_req = r; m1_addr = a; m1_wdata = wd; m1_rw = rw;
        end
    endtask

    task automatic idle_in();
        rst = 1'b0;
        drive_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
        bus_rdy = 1'b0;
        bus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction from master m; slave answers on valid cycle rdy_at
    // (0 = never); chg_at != 0 scrambles the request and drops req then.
    task automatic run_txn(input int m, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input int rdy_at,
                           input logic [31:0] rdval, input int chg_at,
                           output int nvalid, output int nack, output int nother,
                           output int bad, output logic err, output logic [31:0] rd);
        logic am, ao;
        nvalid = 0; nack = 0; nother = 0; bad = 0; err = 1'bx; rd = 32'hx;
        drive_req(m, 1'b1, addr, wdata, rw);
        bus_rdy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            am = (m == 0) ? m0_ack : m1_ack;
            ao = (m == 0) ? m1_ack : m0_ack;
            if (bus_valid) begin
                nvalid++;
                if (bus_addr !== addr || bus_wdata !== wdata || bus_rw !== rw) bad++;
            end
            if (am) begin
                nack++;
                err = (m == 0) ? m0_err : m1_err;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                drive_req(m, 1'b0, addr, wdata, rw);
            end
            if (ao) nother++;
            if (chg_at != 0 && bus_valid && nvalid == chg_at)
                drive_req(m, 1'b0, ~addr, ~wdata, ~rw);
            bus_rdy   = bus_valid && rdy_at != 0 && nvalid == rdy_at;
            bus_rdata = bus_rdy ? rdval : 32'hDEAD_BEEF;
        end
        bus_rdy = 1'b0;
    endtask

    typedef struct {
        logic        rst, r0, r1, rdy;
        logic [31:0] rdata;
        logic        e_valid, e_ack0, e_ack1;
        logic [31:0] e_addr, e_rd0, e_rd1;
    } vec_t;

    vec_t tbl[13];

    // Reference model state: one outstanding transaction at most.
    logic        md_busy = 1'b0;
    int          md_age  = 0;
    int          md_owner = 0;
    logic        md_last = 1'b1;
    logic [31:0] md_addr = 32'h0, md_wdata = 32'h0;
    logic        md_rw = 1'b0;
    logic [1:0]  md_ack = 2'b00, md_err = 2'b00;
    logic [31:0] md_rdata [2] = '{32'h0, 32'h0};

    task automatic md_finish(input logic e);
        md_ack[md_owner] = 1'b1;
        md_err[md_owner] = e;
        if (e) md_rdata[md_owner] = 32'h0;
        else if (!md_rw) md_rdata[md_owner] = bus_rdata;
        md_last = (md_owner == 1);
        md_busy = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] elig;
        int w;
        if (rst) begin
            md_busy = 1'b0; md_age = 0; md_last = 1'b1;
            md_addr = 32'h0; md_wdata = 32'h0; md_rw = 1'b0;
            md_ack = 2'b00; md_err = 2'b00;
            md_rdata[0] = 32'h0; md_rdata[1] = 32'h0;
            return;
        end
        elig = {m1_req, m0_req} & ~md_ack;
        md_ack = 2'b00;
        if (!md_busy) begin
            w = -1;
            if (elig == 2'b11) w = md_last ? 0 : 1;
            else if (elig[0]) w = 0;
            else if (elig[1]) w = 1;
            if (w >= 0) begin
                md_busy  = 1'b1;
                md_owner = w;
                md_age   = 1;
                md_addr  = (w == 0) ? m0_addr : m1_addr;
                md_wdata = (w == 0) ? m0_wdata : m1_wdata;
                md_rw    = (w == 0) ? m0_rw : m1_rw;
            end
        end else if (bus_rdy) begin
            md_finish(1'b0);
        end else if (md_age == TMO) begin
            md_finish(1'b1);
        end else begin
            md_age++;
        end
    endtask

    initial begin
        int nv, na, no, bad;
        logic er;
        logic [31:0] rd;

        tbl[0]  = '{1,1,1,0,32'h00, 0,0,0,32'h000,32'h00,32'h00};
        tbl[1]  = '{0,1,1,0,32'h00, 1,0,0,32'h100,32'h00,32'h00};
        tbl[2]  = '{0,1,1,1,32'h11, 0,1,0,32'h100,32'h11,32'h00};
        tbl[3]  = '{0,1,1,0,32'h00, 1,0,0,32'h200,32'h11,32'h00};
        tbl[4]  = '{0,1,1,1,32'h22, 0,0,1,32'h200,32'h11,32'h22};
        tbl[5]  = '{0,1,1,0,32'h00, 1,0,0,32'h100,32'h11,32'h22};
        tbl[6]  = '{0,1,1,1,32'h33, 0,1,0,32'h100,32'h33,32'h22};
        tbl[7]  = '{0,1,1,0,32'h00, 1,0,0,32'h200,32'h33,32'h22};
        tbl[8]  = '{0,0,1,1,32'h44, 0,0,1,32'h200,32'h33,32'h44};
        tbl[9]  = '{0,0,0,0,32'h00, 0,0,0,32'h200,32'h33,32'h44};
        tbl[10] = '{0,1,1,0,32'h00, 1,0,0,32'h100,32'h33,32'h44};
        tbl[11] = '{0,1,1,1,32'h55, 0,1,0,32'h100,32'h55,32'h44};
        tbl[12] = '{0,0,0,0,32'h00, 0,0,0,32'h100,32'h55,32'h44};

        idle_in();
        @(negedge clk);

        // Contention and round-robin table.
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst;
            drive_req(0, tbl[i].r0, 32'h100, 32'h0, 1'b0);
            drive_req(1, tbl[i].r1, 32'h200, 32'h0, 1'b0);
            bus_rdy = tbl[i].rdy;
            bus_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), bus_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d acks", i), {m1_ack, m0_ack}, {tbl[i].e_ack1, tbl[i].e_ack0});
            chk($sformatf("vec%0d addr", i), bus_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d rd0", i), m0_rdata, tbl[i].e_rd0);
            chk($sformatf("vec%0d rd1", i), m1_rdata, tbl[i].e_rd1);
        end

        // Single read, slave ready on the third valid cycle.
        do_reset();
        chk("reset valid", bus_valid, 1'b0);
        run_txn(0, 1'b0, 32'h10, 32'h0, 3, 32'hA5A5_0001, 0, nv, na, no, bad, er, rd);
        chk("read nvalid", nv, 3);
        chk("read nack", na, 1);
        chk("read other ack", no, 0);
        chk("read bus stable", bad, 0);
        chk("read err", er, 1'b0);
        chk("read rdata", rd, 32'hA5A5_0001);

        // A write completion leaves rdata alone.
        run_txn(0, 1'b1, 32'h14, 32'h9999, 1, 32'h7777_7777, 0, nv, na, no, bad, er, rd);
        chk("write nack", na, 1);
        chk("write rdata kept", rd, 32'hA5A5_0001);

        // m1 read to make rdata non-zero, then a timed-out write.
        run_txn(1, 1'b0, 32'h20, 32'h0, 1, 32'h5555_AAAA, 0, nv, na, no, bad, er, rd);
        chk("m1 read rdata", rd, 32'h5555_AAAA);
        run_txn(1, 1'b1, 32'h40, 32'hCAFE, 0, 32'h0, 0, nv, na, no, bad, er, rd);
        chk("timeout nvalid", nv, TMO);
        chk("timeout nack", na, 1);
        chk("timeout err", er, 1'b1);
        chk("timeout rdata", rd, 32'h0);
        chk("timeout bus stable", bad, 0);

        // Slave answers on the last cycle before abort.
        run_txn(0, 1'b0, 32'h30, 32'h0, TMO, 32'h1234, 0, nv, na, no, bad, er, rd);
        chk("late rdy nvalid", nv, TMO);
        chk("late rdy nack", na, 1);
        chk("late rdy err", er, 1'b0);
        chk("late rdy rdata", rd, 32'h1234);

        // Requester scrambles address and drops req mid-transaction.
        run_txn(0, 1'b0, 32'h80, 32'h0, 4, 32'hBEEF, 2, nv, na, no, bad, er, rd);
        chk("chg bus stable", bad, 0);
        chk("chg nvalid", nv, 4);
        chk("chg nack", na, 1);
        chk("chg rdata", rd, 32'hBEEF);

        // Reset in BUSY: no ack, reset values, m0 wins the next tie.
        do_reset();
        run_txn(0, 1'b0, 32'h500, 32'h0, 1, 32'h77, 0, nv, na, no, bad, er, rd);
        chk("pre-rst rdata", rd, 32'h77);
        drive_req(1, 1'b1, 32'h300, 32'h3, 1'b0);
        drive_req(0, 1'b1, 32'h600, 32'h0, 1'b0);
        @(negedge clk);
        chk("rr after m0", {bus_valid, bus_addr}, {1'b1, 32'h300});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst valid", bus_valid, 1'b0);
        chk("rst addr", bus_addr, 32'h0);
        chk("rst acks", {m1_ack, m0_ack}, 2'b00);
        chk("rst rdata", m0_rdata, 32'h0);
        @(negedge clk);
        chk("post-rst tie", {bus_valid, bus_addr}, {1'b1, 32'h600});
        chk("post-rst no m1 ack", m1_ack, 1'b0);
        bus_rdy = 1'b1;
        @(negedge clk);
        chk("post-rst ack", {m1_ack, m0_ack}, 2'b01);
        idle_in();

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("rand bus", {bus_valid, bus_rw, bus_addr, bus_wdata},
                    {md_busy, md_rw, md_addr, md_wdata});
                chk("rand m0", {m0_ack, m0_err, m0_rdata}, {md_ack[0], md_err[0], md_rdata[0]});
                chk("rand m1", {m1_ack, m1_err, m1_rdata}, {md_ack[1], md_err[1], md_rdata[1]});
            end
            rst = (k == 0) || ($urandom % 400 == 0);
            if (m0_req && md_ack[0] && ($urandom % 2 == 0)) m0_req = 1'b0;
            else if (!m0_req && ($urandom % 3 == 0)) m0_req = 1'b1;
            if (m1_req && md_ack[1] && ($urandom % 2 == 0)) m1_req = 1'b0;
            else if (!m1_req && ($urandom % 3 == 0)) m1_req = 1'b1;
            m0_addr = $urandom; m0_wdata = $urandom; m0_rw = 1'($urandom);
            m1_addr = $urandom; m1_wdata = $urandom; m1_rw = 1'($urandom);
            bus_rdy = ($urandom % 8 == 0);
            bus_rdata = $urandom;
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
